spi_register_bridge: RTL
========================

Name: spi_register_bridge

Overview:
- Consumes fixed-width words from the SPI slave stage and decodes each as a register command {write flag, address, data}.
- Executes the command on a simple req/ack register bus.
- Drives the response word back into the slave's transmit input, where it is shifted out during the next SPI transaction.
- Sits directly downstream of the SPI slave and is the only path from SPI into the system register space.

Parameters:
- WIDTH, 32, SPI word width; must equal the slave's WIDTH; legal range ≥ ADDR_WIDTH+3.
- ADDR_WIDTH, 7, register address width.
- TIMEOUT, 255, max cycles bus_req may wait for bus_ack before abort; 0 disables the timeout.

Ports:
- system_clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- value_mosi  in  WIDTH  received word from the SPI slave.
- value_valid  in  1  one-cycle pulse: value_mosi holds a complete word.
- cs_stop  in  1  one-cycle pulse at end of any SPI transaction.
- value_miso  out  WIDTH  response word, registered; captured by the slave at its cs_start.
- bus_addr  out  ADDR_WIDTH  register address.
- bus_wdata  out  DW  write data, where DW = WIDTH-1-ADDR_WIDTH.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req is high.
- bus_req  out  1  request; held until ack or timeout.
- bus_ack  in  1  one-cycle completion strobe from the register bus.
- bus_rdata  in  DW  read data, valid on the bus_ack cycle.
- busy  out  1  high while in REQ.
- error_count  out  8  saturating count of frame errors, overruns and timeouts.

Behaviour:
- Command word layout:
  - bit WIDTH-1 = write flag.
  - bits [WIDTH-2 : DW] = address.
  - bits [DW-1:0] = data.
- Response word layout:
  - bit WIDTH-1 = done.
  - bit WIDTH-2 = err.
  - bits [WIDTH-3 : DW] = addr[ADDR_WIDTH-2:0] echo.
  - bits [DW-1:0] = payload (read data, or the written data echoed).
- Reset (synchronous, active-high; wins over every other event):
  - state=IDLE; value_miso=0; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0; busy=0; error_count=0.
  - Reset asserted while in REQ: bus_req is low on the cycle after reset is sampled; the pending command is discarded.
- Inputs from the slave are sampled on the rising edge. The slave updates them on the falling edge, so this is a half-cycle path with no synchronizer.
- State IDLE:
  - value_valid=1 at cycle N:
    - Latch bus_addr, bus_wdata and bus_we from the command word.
    - value_miso <= 0, meaning "pending".
    - bus_req=1 and busy=1 from cycle N+1.
    - Clear the wait counter; go to REQ.
  - cs_stop=1 with value_valid=0 (incomplete frame):
    - value_miso <= {1,1,0…0}; error_count += 1; stay in IDLE.
- State REQ:
  - Wait counter increments each cycle bus_req is high.
  - bus_ack=1:
    - value_miso <= {1, 0, addr echo, bus_we ? bus_wdata : bus_rdata}.
    - bus_req=0 and busy=0 on the next cycle; go to IDLE.
  - TIMEOUT≠0, counter reaches TIMEOUT, no ack:
    - value_miso <= {1, 1, addr echo, 0}; bus_req dropped; error_count += 1; go to IDLE.
  - bus_ack on the same cycle the timeout is reached: ack wins, no error.
  - value_valid or cs_stop while in REQ: the frame is dropped (overrun); error_count += 1; the bus transaction is unaffected.
- bus_ack while in IDLE: ignored.
- Bus outputs are stable for the whole time bus_req is high.
- Minimum latency: value_valid to bus_req = 1 cycle; bus_ack to updated value_miso = 1 cycle.
- error_count saturates at 255 and does not wrap; two error events in one cycle count as one.
- The SPI master reads each response during its next transaction. done=0 in that response means the previous command was still pending when the slave captured value_miso.

Test Plan:
- Write (WIDTH=32, ADDR_WIDTH=7): value_valid with value_mosi=0x85_00ABCD (write, addr 0x05, data 0x00ABCD) -> next cycle bus_req=1, bus_we=1, bus_addr=0x05, bus_wdata=0x00ABCD; ack after 3 cycles -> bus_req low next cycle, value_miso=0x8500ABCD.
- Read: value_mosi=0x12_000000 (read, addr 0x12), bus_rdata=0x123456 on ack -> value_miso=0x92123456, bus_we=0.
- Timeout (TIMEOUT=4): read of addr 0x03, no ack -> bus_req high exactly 4 cycles, then value_miso=0xC3000000, error_count=1.
- Incomplete frame: cs_stop without value_valid in IDLE -> value_miso=0xC0000000, error_count increments, bus_req stays 0. Overrun: value_valid during REQ -> frame dropped, error_count increments, in-flight bus_addr unchanged.
- Reset mid-REQ -> next cycle bus_req=0, value_miso=0, error_count=0; a subsequent valid write completes normally. Apply 300 errors -> error_count=255.
- Ack and timeout in the same cycle (TIMEOUT=2, ack on the 2nd wait cycle) -> err=0, payload = bus_rdata, error_count unchanged.

Source files
------------

// File: rtl/spi_register_bridge.sv
// Bridges 32-bit-style SPI command words onto a req/ack register bus and
// builds the response word the SPI slave shifts out on the next transaction.
//
// state | meaning
// IDLE  | waiting for a command word; cs_stop alone flags an incomplete frame
// REQ   | bus_req held high until bus_ack or wait-timer expiry
module spi_register_bridge #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int TIMEOUT    = 255
) (
   input  logic                          system_clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              value_mosi,
   input  logic                          value_valid,
   input  logic                          cs_stop,
   output logic [WIDTH-1:0]              value_miso,
   output logic [ADDR_WIDTH-1:0]         bus_addr,
   output logic [WIDTH-ADDR_WIDTH-2:0]   bus_wdata,
   output logic                          bus_we,
   output logic                          bus_req,
   input  logic                          bus_ack,
   input  logic [WIDTH-ADDR_WIDTH-2:0]   bus_rdata,
   output logic                          busy,
   output logic [7:0]                    error_count
);

   localparam int DW = WIDTH - 1 - ADDR_WIDTH;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      miso_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DW-1:0]         wdata_nxt;
   logic                  we_nxt;
   logic [CW-1:0]         wait_cnt, wait_nxt;
   logic                  err_evt;

   always_ff @(posedge system_clk) begin
      if (rst) begin
         state       <= IDLE;
         value_miso  <= '0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         bus_we      <= 1'b0;
         wait_cnt    <= '0;
         error_count <= '0;
      end else begin
         state      <= state_nxt;
         value_miso <= miso_nxt;
         bus_addr   <= addr_nxt;
         bus_wdata  <= wdata_nxt;
         bus_we     <= we_nxt;
         wait_cnt   <= wait_nxt;
         if (err_evt && error_count != 8'hFF)
            error_count <= error_count + 8'd1;
      end
   end

   // Wait timer counts down from TIMEOUT; expiry is the cycle it would hit zero.
   always_comb begin
      state_nxt = state;
      miso_nxt  = value_miso;
      addr_nxt  = bus_addr;
      wdata_nxt = bus_wdata;
      we_nxt    = bus_we;
      wait_nxt  = wait_cnt;
      err_evt   = 1'b0;
      case (state)
         IDLE: begin
            if (value_valid) begin
               we_nxt    = value_mosi[WIDTH-1];
               addr_nxt  = value_mosi[WIDTH-2:DW];
               wdata_nxt = value_mosi[DW-1:0];
               miso_nxt  = '0;
               wait_nxt  = CW'(TIMEOUT);
               state_nxt = REQ;
            end else if (cs_stop) begin
               miso_nxt = {2'b11, {(WIDTH-2){1'b0}}};
               err_evt  = 1'b1;
            end
         end
         REQ: begin
            err_evt = value_valid | cs_stop;
            if (bus_ack) begin
               miso_nxt  = {2'b10, bus_addr[ADDR_WIDTH-2:0],
                            bus_we ? bus_wdata : bus_rdata};
               state_nxt = IDLE;
            end else if (TIMEOUT != 0 && wait_cnt == CW'(1)) begin
               miso_nxt  = {2'b11, bus_addr[ADDR_WIDTH-2:0], {DW{1'b0}}};
               err_evt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               wait_nxt = wait_cnt - CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus_req = (state == REQ);
   assign busy    = (state == REQ);

endmodule
